// File: rtl/stream_deser_if.sv
// Flit-in / word-out stream bundle for stream_deser.
// The slave modport is the deserializer; the master modport is whoever feeds flits
// and consumes assembled words.
interface stream_deser_if #(
  parameter int dw = 16,
  parameter int N  = 4
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [dw-1:0]   d_in;
  logic            req_in;
  logic            ack_in;
  logic [N*dw-1:0] d_out;
  logic            req_out;
  logic            ack_out;
  logic [CW-1:0]   flit_cnt;

  modport master (
    output d_in, req_in, ack_out,
    input  ack_in, d_out, req_out, flit_cnt
  );

  modport slave (
    input  d_in, req_in, ack_out,
    output ack_in, d_out, req_out, flit_cnt
  );
endinterface

// File: rtl/stream_deser.sv
// Collects N flits of dw bits from a req/ack stream into one N*dw-bit word.
// Latency: req_out rises on the edge that accepts the Nth flit (zero added cycles).
// Backpressure: while a word waits, ack_in follows ack_out, so upstream stalls only when downstream does.
module stream_deser #(
  parameter int dw        = 16,
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic           clk,
  input logic           rstn,
  stream_deser_if.slave s
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {COLLECT, OUTPUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic [CW-1:0] wr_slot;
  logic [dw-1:0] slot_q [N];

  // State and flit counter; reset abandons any partial or pending word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, slot write strobe and upstream ready.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_slot  = cnt_q;
    s.ack_in = 1'b1;
    unique case (state_q)
      COLLECT: begin
        s.ack_in = 1'b1;
        if (s.req_in) begin
          wr_en   = 1'b1;
          wr_slot = cnt_q;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = OUTPUT;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      OUTPUT: begin
        // A flit may only enter in the same cycle the held word leaves,
        // which keeps one word per N cycles under continuous traffic.
        s.ack_in = s.ack_out;
        if (s.ack_out) begin
          state_d = COLLECT;
          if (s.req_in) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            if (N == 1) begin
              // A single flit is already a full word: go straight back to holding.
              state_d = OUTPUT;
              cnt_d   = '0;
            end else begin
              cnt_d = ONE;
            end
          end
        end
      end
    endcase
  end

  // Slot storage; slots not rewritten keep stale data from the previous word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en && (wr_slot == CW'(i))) slot_q[i] <= s.d_in;
      end
    end
  end

  assign s.req_out  = (state_q == OUTPUT);
  assign s.flit_cnt = cnt_q;

  // Slot i lands low-first or high-first depending on MSB_FIRST.
  for (genvar i = 0; i < N; i++) begin : g_map
    localparam int POS = MSB_FIRST ? (N - 1 - i) : i;
    assign s.d_out[POS*dw +: dw] = slot_q[i];
  end

  // The counter never reaches N.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rstn)
    cnt_q <= LAST);

  // A word that is not taken stays put, unchanged.
  a_hold: assert property (@(posedge clk) disable iff (!rstn)
    (s.req_out && !s.ack_out) |=> (s.req_out && $stable(s.d_out)));

  // Nothing enters while a word is stalled downstream.
  a_stall: assert property (@(posedge clk) disable iff (!rstn)
    (s.req_out && !s.ack_out) |-> !s.ack_in);

endmodule

// File: tb/tb_stream_deser.sv
// Bench for stream_deser: LSB-first and MSB-first instances driven by the same
// stimulus; expected words are queued at issue time and checked by a monitor.
module tb_stream_deser;
  localparam int DW = 16;
  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] d_in;
  logic          req_in;
  logic          ack_out;

  always #5 clk = ~clk;

  stream_deser_if #(.dw(DW), .N(NF)) if_l ();
  stream_deser_if #(.dw(DW), .N(NF)) if_m ();

  assign if_l.d_in    = d_in;
  assign if_l.req_in  = req_in;
  assign if_l.ack_out = ack_out;
  assign if_m.d_in    = d_in;
  assign if_m.req_in  = req_in;
  assign if_m.ack_out = ack_out;

  stream_deser #(.dw(DW), .N(NF), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rstn(rstn), .s(if_l.slave));
  stream_deser #(.dw(DW), .N(NF), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rstn(rstn), .s(if_m.slave));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected words, one queue per slot ordering.
  logic [63:0] exp_l_q[$];
  logic [63:0] exp_m_q[$];

  task automatic expect_word(input logic [15:0] f0, input logic [15:0] f1,
                             input logic [15:0] f2, input logic [15:0] f3);
    exp_l_q.push_back({f3, f2, f1, f0});
    exp_m_q.push_back({f0, f1, f2, f3});
  endtask

  // Reference handshake model: pending-word flag, flit count, slot contents.
  bit          m_pend;
  int          m_cnt;
  logic [15:0] m_slot [NF];
  bit          use_model = 1'b0;
  bit          mon_en    = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pend = 1'b0;
      m_cnt  = 0;
    end else begin
      bit acc;
      acc = req_in && (!m_pend || ack_out);
      if (m_pend && ack_out) m_pend = 1'b0;
      if (acc) begin
        m_slot[m_cnt] = d_in;
        if (m_cnt == NF - 1) begin
          m_cnt  = 0;
          m_pend = 1'b1;
          if (use_model) expect_word(m_slot[0], m_slot[1], m_slot[2], m_slot[3]);
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Monitor: handshake outputs every cycle, word contents on each word transfer.
  bit          prev_hold = 1'b0;
  logic [63:0] prev_l, prev_m;

  always @(negedge clk) begin
    if (rstn && mon_en) begin
      chk("req_out_l", {63'd0, if_l.req_out}, {63'd0, m_pend});
      chk("req_out_m", {63'd0, if_m.req_out}, {63'd0, m_pend});
      chk("ack_in_l", {63'd0, if_l.ack_in}, {63'd0, (!m_pend || ack_out)});
      chk("ack_in_m", {63'd0, if_m.ack_in}, {63'd0, (!m_pend || ack_out)});
      chk("flit_cnt_l", {62'd0, if_l.flit_cnt}, {62'd0, m_cnt[1:0]});
      chk("flit_cnt_m", {62'd0, if_m.flit_cnt}, {62'd0, m_cnt[1:0]});
      if (prev_hold) begin
        chk("hold_l", if_l.d_out, prev_l);
        chk("hold_m", if_m.d_out, prev_m);
      end
      prev_hold = if_l.req_out && !ack_out;
      prev_l    = if_l.d_out;
      prev_m    = if_m.d_out;
      if (if_l.req_out && ack_out) begin
        if (exp_l_q.size() == 0) begin
          n_total++;
          $display("FAIL word_l: got unexpected word %h, expected none", if_l.d_out);
        end else chk("word_l", if_l.d_out, exp_l_q.pop_front());
      end
      if (if_m.req_out && ack_out) begin
        if (exp_m_q.size() == 0) begin
          n_total++;
          $display("FAIL word_m: got unexpected word %h, expected none", if_m.d_out);
        end else chk("word_m", if_m.d_out, exp_m_q.pop_front());
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  // One clock of stimulus, applied just after the rising edge.
  task automatic cyc(input bit rq, input logic [15:0] d, input bit ao);
    req_in  = rq;
    d_in    = d;
    ack_out = ao;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn    = 1'b0;
    req_in  = 1'b0;
    d_in    = '0;
    ack_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_out_l", {63'd0, if_l.req_out}, 64'd0);
    chk("rst_req_out_m", {63'd0, if_m.req_out}, 64'd0);
    chk("rst_flit_cnt_l", {62'd0, if_l.flit_cnt}, 64'd0);
    chk("rst_flit_cnt_m", {62'd0, if_m.flit_cnt}, 64'd0);
    chk("rst_d_out_l", if_l.d_out, 64'd0);
    chk("rst_d_out_m", if_m.d_out, 64'd0);
    rstn   = 1'b1;
    mon_en = 1'b1;

    // Four back-to-back flits; word valid on the edge taking the last, for one cycle.
    expect_word(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    cyc(1, 16'h1111, 1);
    cyc(1, 16'h2222, 1);
    cyc(1, 16'h3333, 1);
    cyc(1, 16'h4444, 1);
    chk("t1_latency_req_out", {63'd0, if_l.req_out}, 64'd1);
    chk("t1_d_out_l", if_l.d_out, 64'h4444_3333_2222_1111);
    chk("t1_d_out_m", if_m.d_out, 64'h1111_2222_3333_4444);
    cyc(0, 16'h0000, 1);
    chk("t1_pulse_end", {63'd0, if_l.req_out}, 64'd0);

    // Stalled word with a flit waiting upstream.
    expect_word(16'hB001, 16'hB002, 16'hB003, 16'hB004);
    cyc(1, 16'hB001, 1);
    cyc(1, 16'hB002, 1);
    cyc(1, 16'hB003, 1);
    cyc(1, 16'hB004, 0);
    for (int i = 0; i < 5; i++) begin
      req_in  = 1'b1;
      d_in    = 16'hAAAA;
      ack_out = 1'b0;
      #1;
      chk("t3_ack_in_stall", {63'd0, if_l.ack_in}, 64'd0);
      chk("t3_flit_cnt_stall", {62'd0, if_l.flit_cnt}, 64'd0);
      chk("t3_d_out_stable", if_l.d_out, 64'hB004_B003_B002_B001);
      @(posedge clk);
      #1;
    end
    expect_word(16'hAAAA, 16'hC002, 16'hC003, 16'hC004);
    cyc(1, 16'hAAAA, 1);
    chk("t3_flit_cnt_after", {62'd0, if_l.flit_cnt}, 64'd1);
    chk("t3_req_out_after", {63'd0, if_l.req_out}, 64'd0);
    cyc(1, 16'hC002, 1);
    cyc(1, 16'hC003, 1);
    cyc(1, 16'hC004, 1);
    cyc(0, 16'h0000, 1);

    // Continuous traffic: 40 incrementing flits form 10 words, no stalls.
    for (int k = 0; k < 10; k++)
      expect_word(16'(4*k), 16'(4*k+1), 16'(4*k+2), 16'(4*k+3));
    for (int i = 0; i < 40; i++) cyc(1, 16'(i), 1);
    cyc(0, 16'h0000, 1);

    // Asynchronous reset mid-word discards the partial word.
    cyc(1, 16'h00F1, 1);
    cyc(1, 16'h00F2, 1);
    req_in = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    chk("t5_rst_flit_cnt_l", {62'd0, if_l.flit_cnt}, 64'd0);
    chk("t5_rst_req_out_l", {63'd0, if_l.req_out}, 64'd0);
    chk("t5_rst_flit_cnt_m", {62'd0, if_m.flit_cnt}, 64'd0);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    expect_word(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    cyc(1, 16'h0005, 1);
    cyc(1, 16'h0006, 1);
    cyc(1, 16'h0007, 1);
    cyc(1, 16'h0008, 1);
    chk("t5_word_l", if_l.d_out, 64'h0008_0007_0006_0005);
    cyc(0, 16'h0000, 1);

    // Random traffic against the reference model.
    use_model = 1'b1;
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 8; i++) cyc(0, 16'h0000, 1);
    chk("drain_l", 64'(exp_l_q.size()), 64'd0);
    chk("drain_m", 64'(exp_m_q.size()), 64'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
